// File: rtl/pong_pkg.sv
// Shared types, screen geometry and the paddle step helper for the Pong game sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StScore,
        StGameOver
    } state_e;

    localparam int unsigned SCREEN = 64;
    localparam int unsigned P1_COL = 0;
    localparam int unsigned P2_COL = 62;
    localparam int unsigned CENTRE = 31;

    // One-row paddle move; both or neither button pressed leaves it in place.
    function automatic logic [5:0] paddle_step(input logic [5:0] y, input logic up,
                                               input logic dn, input logic [5:0] y_max);
        logic [5:0] r;
        r = y;
        if (up && !dn && y != 6'd0) begin
            r = y - 6'd1;
        end else if (dn && !up && y < y_max) begin
            r = y + 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running divider producing a one-cycle game tick every TICK_DIV clocks.
module pong_tick_gen #(
    parameter int unsigned TICK_DIV = 390625
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: ball, paddles and scores advanced once per game tick.
// Define PONG_AUTO_P2_EN to make the P2 paddle track the ball instead of p2_up/p2_dn.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 390625,
    parameter int unsigned PADDLE_H   = 6,
    parameter int unsigned WIN_SCORE  = 7,
    parameter int unsigned SERVE_WAIT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic       frame_upd,
    output logic       game_over,
    output logic       winner
);

    localparam logic [5:0] Y_MAX   = 6'(SCREEN - PADDLE_H);
    localparam logic [5:0] COL_MAX = 6'(SCREEN - 1);
    localparam logic [5:0] CTR     = 6'(CENTRE);
    localparam logic [5:0] P1_HIT  = 6'(P1_COL + 2);
    localparam logic [5:0] P2_HIT  = 6'(P2_COL - 1);
    localparam logic [6:0] PH_SPAN = 7'(PADDLE_H - 1);
    localparam logic [2:0] WIN     = 3'(WIN_SCORE);
    localparam int unsigned SCW    = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;
    localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_WAIT - 1);

    state_e         state_q, state_d;
    logic [5:0]     bx_q, bx_d, by_q, by_d, p1y_q, p1y_d, p2y_q, p2y_d;
    logic [2:0]     sc1_q, sc1_d, sc2_q, sc2_d;
    logic           dx_q, dx_d, dy_q, dy_d;  // 1 = +1, 0 = -1
    logic [SCW-1:0] scnt_q, scnt_d;
    logic           scorer_q, scorer_d;      // 1 = P2 took the point
    logic           winner_q, winner_d, frame_upd_q, frame_upd_d, game_over_q, game_over_d;

    logic           tick;
    logic [5:0]     p1y_mv, p2y_mv, bx_n, by_n;
    logic           dx_n, dy_n, p1_hit, p2_hit, miss, miss_by_p2;
    logic [2:0]     sc_inc;

    pong_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_comb p1y_mv = paddle_step(p1y_q, p1_up, p1_dn, Y_MAX);

`ifdef PONG_AUTO_P2_EN
    localparam logic [6:0] HALF = 7'(PADDLE_H / 2);
    logic [6:0] p2_tgt;

    always_comb begin
        p2_tgt = ({1'b0, by_q} <= HALF) ? 7'd0 : {1'b0, by_q} - HALF;
        if (p2_tgt > {1'b0, Y_MAX}) p2_tgt = {1'b0, Y_MAX};
        if ({1'b0, p2y_q} < p2_tgt) begin
            p2y_mv = p2y_q + 6'd1;
        end else if ({1'b0, p2y_q} > p2_tgt) begin
            p2y_mv = p2y_q - 6'd1;
        end else begin
            p2y_mv = p2y_q;
        end
    end
`else
    always_comb p2y_mv = paddle_step(p2y_q, p2_up, p2_dn, Y_MAX);
`endif

    // Ball step for a PLAY tick; paddle hits test the already-moved paddles.
    always_comb begin
        dy_n = dy_q;
        if (by_q == 6'd0 && !dy_q) begin
            by_n = 6'd1;
            dy_n = 1'b1;
        end else if (by_q == COL_MAX && dy_q) begin
            by_n = COL_MAX - 6'd1;
            dy_n = 1'b0;
        end else begin
            by_n = dy_q ? by_q + 6'd1 : by_q - 6'd1;
        end

        p1_hit = (bx_q == P1_HIT) && !dx_q && ({1'b0, by_q} >= {1'b0, p1y_mv})
                 && ({1'b0, by_q} <= {1'b0, p1y_mv} + PH_SPAN);
        p2_hit = (bx_q == P2_HIT) && dx_q && ({1'b0, by_q} >= {1'b0, p2y_mv})
                 && ({1'b0, by_q} <= {1'b0, p2y_mv} + PH_SPAN);

        dx_n       = dx_q;
        miss       = 1'b0;
        miss_by_p2 = 1'b0;
        bx_n       = bx_q;
        if (p1_hit) begin
            bx_n = P1_HIT + 6'd1;
            dx_n = 1'b1;
        end else if (bx_q == 6'd0 && !dx_q) begin
            miss       = 1'b1;
            miss_by_p2 = 1'b1;
        end else if (p2_hit) begin
            bx_n = P2_HIT - 6'd1;
            dx_n = 1'b0;
        end else if (bx_q == COL_MAX && dx_q) begin
            miss = 1'b1;
        end else begin
            bx_n = dx_q ? bx_q + 6'd1 : bx_q - 6'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        bx_d        = bx_q;
        by_d        = by_q;
        p1y_d       = p1y_q;
        p2y_d       = p2y_q;
        sc1_d       = sc1_q;
        sc2_d       = sc2_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        scnt_d      = scnt_q;
        scorer_d    = scorer_q;
        winner_d    = winner_q;
        frame_upd_d = 1'b0;
        sc_inc      = scorer_q ? sc2_q + 3'd1 : sc1_q + 3'd1;

        case (state_q)
            StIdle, StGameOver: begin
                if (start) begin
                    state_d = StServe;
                    sc1_d   = '0;
                    sc2_d   = '0;
                    bx_d    = CTR;
                    by_d    = CTR;
                    scnt_d  = '0;
                end
            end
            StServe: begin
                if (tick) begin
                    p1y_d       = p1y_mv;
                    p2y_d       = p2y_mv;
                    bx_d        = CTR;
                    by_d        = CTR;
                    frame_upd_d = 1'b1;
                    if (scnt_q == SERVE_LAST) begin
                        state_d = StPlay;
                        scnt_d  = '0;
                    end else begin
                        scnt_d = scnt_q + SCW'(1);
                    end
                end
            end
            StPlay: begin
                if (tick) begin
                    p1y_d       = p1y_mv;
                    p2y_d       = p2y_mv;
                    frame_upd_d = 1'b1;
                    if (miss) begin
                        state_d  = StScore;
                        scorer_d = miss_by_p2;
                    end else begin
                        bx_d = bx_n;
                        by_d = by_n;
                        dx_d = dx_n;
                        dy_d = dy_n;
                    end
                end
            end
            StScore: begin
                frame_upd_d = 1'b1;
                bx_d        = CTR;
                by_d        = CTR;
                dx_d        = ~scorer_q;  // serve toward whoever conceded
                if (scorer_q) sc2_d = sc_inc;
                else          sc1_d = sc_inc;
                if (sc_inc == WIN) begin
                    state_d  = StGameOver;
                    winner_d = scorer_q;
                end else begin
                    state_d = StServe;
                    scnt_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        game_over_d = (state_d == StGameOver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bx_q        <= CTR;
            by_q        <= CTR;
            p1y_q       <= 6'd29;
            p2y_q       <= 6'd29;
            sc1_q       <= '0;
            sc2_q       <= '0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            scnt_q      <= '0;
            scorer_q    <= 1'b0;
            winner_q    <= 1'b0;
            frame_upd_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            p1y_q       <= p1y_d;
            p2y_q       <= p2y_d;
            sc1_q       <= sc1_d;
            sc2_q       <= sc2_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            scnt_q      <= scnt_d;
            scorer_q    <= scorer_d;
            winner_q    <= winner_d;
            frame_upd_q <= frame_upd_d;
            game_over_q <= game_over_d;
        end
    end

    assign bx        = bx_q;
    assign by        = by_q;
    assign p1y       = p1y_q;
    assign p2y       = p2y_q;
    assign sc1       = sc1_q;
    assign sc2       = sc2_q;
    assign frame_upd = frame_upd_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
